// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and the glyph table for the multiplexed
// seven-segment display driver.
//   seg_t           segments a..g, index 0 = a, active-high (1 = lit)
//   GLYPH_*         5-bit glyph codes beyond the hex range
//   glyph_to_seg()  glyph code -> active-high segment pattern
package sseg_pkg;

  typedef logic [0:6] seg_t;

  localparam logic [4:0] GLYPH_BLANK = 5'h10;
  localparam logic [4:0] GLYPH_DASH  = 5'h11;
  localparam logic [4:0] GLYPH_P     = 5'h12;
  localparam logic [4:0] GLYPH_L     = 5'h13;
  localparam logic [4:0] GLYPH_U     = 5'h14;
  localparam logic [4:0] GLYPH_R     = 5'h15;
  localparam logic [4:0] GLYPH_N     = 5'h16;
  localparam logic [4:0] GLYPH_O     = 5'h17;

  localparam seg_t SEG_NONE = 7'b0000000;

  // Literals are written a..g left to right.
  function automatic seg_t glyph_to_seg(input logic [4:0] code);
    seg_t seg_v;
    case (code)
      5'h00:       seg_v = 7'b1111110;
      5'h01:       seg_v = 7'b0110000;
      5'h02:       seg_v = 7'b1101101;
      5'h03:       seg_v = 7'b1111001;
      5'h04:       seg_v = 7'b0110011;
      5'h05:       seg_v = 7'b1011011;
      5'h06:       seg_v = 7'b1011111;
      5'h07:       seg_v = 7'b1110000;
      5'h08:       seg_v = 7'b1111111;
      5'h09:       seg_v = 7'b1111011;
      5'h0A:       seg_v = 7'b1110111;
      5'h0B:       seg_v = 7'b0011111;
      5'h0C:       seg_v = 7'b1001110;
      5'h0D:       seg_v = 7'b0111101;
      5'h0E:       seg_v = 7'b1001111;
      5'h0F:       seg_v = 7'b1000111;
      GLYPH_BLANK: seg_v = SEG_NONE;
      GLYPH_DASH:  seg_v = 7'b0000001;
      GLYPH_P:     seg_v = 7'b1100111;
      GLYPH_L:     seg_v = 7'b0001110;
      GLYPH_U:     seg_v = 7'b0111110;
      GLYPH_R:     seg_v = 7'b0000101;
      GLYPH_N:     seg_v = 7'b0010101;
      GLYPH_O:     seg_v = 7'b0011101;
      default:     seg_v = SEG_NONE;
    endcase
    return seg_v;
  endfunction

endpackage

// File: rtl/sseg_glyph_rom.sv
// sseg_glyph_rom: combinational glyph code to segment lookup.
//   code  in   5  glyph code
//   seg   out  7  segments a..g, active-high
module sseg_glyph_rom
  import sseg_pkg::*;
(
  input  logic [4:0] code,
  output seg_t       seg
);

  // Pure table lookup; no state.
  always_comb begin
    seg = glyph_to_seg(code);
  end

endmodule

// File: rtl/sseg_mux_display.sv
// sseg_mux_display: time-multiplexed common-anode seven-segment driver.
// Scans N_DIGITS digits from a prescaler tick, latches a whole frame of
// inputs at the start of each frame, holds anodes off for a guard time
// after each digit change, and supports blanking, blinking, decimal
// points and leading-zero suppression.
//   clk          in   1           system clock
//   rst          in   1           async active-low reset
//   num          in   5*N_DIGITS  glyph codes, digit 0 in num[4:0]
//   dp           in   N_DIGITS    decimal point request, 1 = lit
//   blank_mask   in   N_DIGITS    1 = digit always dark
//   blink_mask   in   N_DIGITS    1 = digit dark in blink off-phase
//   lzs_en       in   1           leading-zero suppression enable
//   enable       in   1           0 = all anodes off
//   sseg         out  [0:6]       segments a..g, active-low
//   dp_n         out  1           decimal point, active-low
//   an           out  N_DIGITS    anodes, active-low
//   frame_start  out  1           pulse when digit 0 is selected
module sseg_mux_display
  import sseg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int TICK_DIV     = 65536,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*N_DIGITS-1:0] num,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lzs_en,
  input  logic                  enable,
  output logic [0:6]            sseg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int GW = $clog2(GUARD + 2);

  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{1'b1}};
  localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic [PW-1:0]         presc_r;
  logic                  tick_s;
  logic                  started_r;
  logic [IW-1:0]         idx_r;
  logic [IW-1:0]         idx_nxt_s;
  logic                  new_frame_s;
  logic [GW-1:0]         guard_r;
  logic [FW-1:0]         frame_cnt_r;
  logic                  frame_wrap_s;
  logic                  blink_off_r;
  logic                  blink_off_nxt_s;

  logic [5*N_DIGITS-1:0] sh_num_r;
  logic [N_DIGITS-1:0]   sh_dp_r;
  logic [N_DIGITS-1:0]   sh_blank_r;
  logic [N_DIGITS-1:0]   sh_blink_r;
  logic                  sh_lzs_r;

  logic [5*N_DIGITS-1:0] src_num_s;
  logic [N_DIGITS-1:0]   src_dp_s;
  logic [N_DIGITS-1:0]   src_blank_s;
  logic [N_DIGITS-1:0]   src_blink_s;
  logic                  src_lzs_s;
  logic [N_DIGITS-1:0]   supp_s;
  logic [4:0]            code_s;
  logic                  dark_s;
  seg_t                  seg_on_s;

  assign tick_s       = (presc_r == PW'(TICK_DIV - 1));
  assign frame_wrap_s = (frame_cnt_r == FW'(BLINK_FRAMES - 1));

  // Next scan index. The first tick after reset selects digit 0 so every
  // scan after reset begins with a complete frame.
  always_comb begin
    if (!started_r) begin
      idx_nxt_s = {IW{1'b0}};
    end else if (idx_r == IW'(N_DIGITS - 1)) begin
      idx_nxt_s = {IW{1'b0}};
    end else begin
      idx_nxt_s = idx_r + 1'b1;
    end
  end

  assign new_frame_s     = tick_s & (idx_nxt_s == {IW{1'b0}});
  assign blink_off_nxt_s = blink_off_r ^ (new_frame_s & frame_wrap_s);

  // On the frame-start tick the shadows are being loaded this very edge,
  // so digit 0 decodes straight from the inputs being captured.
  always_comb begin
    if (new_frame_s) begin
      src_num_s   = num;
      src_dp_s    = dp;
      src_blank_s = blank_mask;
      src_blink_s = blink_mask;
      src_lzs_s   = lzs_en;
    end else begin
      src_num_s   = sh_num_r;
      src_dp_s    = sh_dp_r;
      src_blank_s = sh_blank_r;
      src_blink_s = sh_blink_r;
      src_lzs_s   = sh_lzs_r;
    end
  end

  // Leading-zero suppression: walk down from the top digit while every
  // digit so far is zero or blanked. Digit 0 is never suppressed.
  always_comb begin
    logic lead_v;
    lead_v = 1'b1;
    supp_s = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      lead_v    = lead_v & (src_blank_s[i] | (src_num_s[5*i +: 5] == 5'h00));
      supp_s[i] = src_lzs_s & lead_v;
    end
  end

  assign code_s = src_num_s[5*idx_nxt_s +: 5];
  assign dark_s = src_blank_s[idx_nxt_s]
                | (src_blink_s[idx_nxt_s] & blink_off_nxt_s)
                | supp_s[idx_nxt_s];

  sseg_glyph_rom u_rom (
    .code (code_s),
    .seg  (seg_on_s)
  );

  // Prescaler: free-running 0..TICK_DIV-1, tick on the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  // Scan index, frame latch and blink phase, all advanced by the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_r   <= 1'b0;
      idx_r       <= {IW{1'b0}};
      frame_cnt_r <= {FW{1'b0}};
      blink_off_r <= 1'b0;
      sh_num_r    <= {(5*N_DIGITS){1'b0}};
      sh_dp_r     <= {N_DIGITS{1'b0}};
      sh_blank_r  <= {N_DIGITS{1'b0}};
      sh_blink_r  <= {N_DIGITS{1'b0}};
      sh_lzs_r    <= 1'b0;
    end else if (tick_s) begin
      started_r   <= 1'b1;
      idx_r       <= idx_nxt_s;
      blink_off_r <= blink_off_nxt_s;
      if (new_frame_s) begin
        frame_cnt_r <= frame_wrap_s ? {FW{1'b0}} : frame_cnt_r + 1'b1;
        sh_num_r    <= num;
        sh_dp_r     <= dp;
        sh_blank_r  <= blank_mask;
        sh_blink_r  <= blink_mask;
        sh_lzs_r    <= lzs_en;
      end
    end
  end

  // Segment and decimal-point outputs change only on the tick edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sseg        <= 7'b1111111;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= new_frame_s;
      if (tick_s) begin
        if (dark_s) begin
          sseg <= 7'b1111111;
          dp_n <= 1'b1;
        end else begin
          sseg <= ~seg_on_s;
          dp_n <= ~src_dp_s[idx_nxt_s];
        end
      end
    end
  end

  // Anodes: off on the tick edge and while the guard count is above one,
  // so the off window lasts GUARD clocks including the tick edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an      <= AN_OFF;
      guard_r <= {GW{1'b0}};
    end else if (tick_s) begin
      an      <= AN_OFF;
      guard_r <= GW'(GUARD);
    end else begin
      if (guard_r != {GW{1'b0}}) begin
        guard_r <= guard_r - 1'b1;
      end
      if (!enable || !started_r || (guard_r > GW'(1))) begin
        an <= AN_OFF;
      end else begin
        an <= ~(AN_ONE << idx_r);
      end
    end
  end

endmodule
